// File: rtl/gal_mon_pkg.sv
// ============================================================================
//  Module      : gal_mon_pkg
//  Description : Shared types and constants for the GAL16V8 I/O monitor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package gal_mon_pkg;

  localparam int         GAL_MON_TS_W     = 16;
  localparam int         GAL_MON_DATA_W   = 8;
  localparam logic [7:0] GAL_MON_DROP_MAX = 8'hFF;

  typedef struct packed {
    logic                      hiz;
    logic [GAL_MON_DATA_W-1:0] data;
    logic [GAL_MON_TS_W-1:0]   ts;
  } gal_evt_t;

endpackage

`default_nettype wire

// File: rtl/gal_mon_fifo.sv
// ============================================================================
//  Module      : gal_mon_fifo
//  Description : Synchronous first-word-fall-through FIFO, async reset.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gal_mon_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_pop;
  logic         do_push;

  // A push into a full FIFO is legal when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/gal_io_monitor.sv
// ============================================================================
//  Module      : gal_io_monitor
//  Description : Timestamped change capture of a GAL output bus with high-Z.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module gal_io_monitor
  import gal_mon_pkg::*;
#(
  parameter int WIDTH = GAL_MON_DATA_W,
  parameter int DEPTH = 8,
  parameter int TS_W  = GAL_MON_TS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] io,
  input  logic             oe_n,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_data,
  output logic             evt_hiz,
  output logic [TS_W-1:0]  evt_ts,
  output logic             ovf,
  output logic [7:0]       drop_cnt,
  input  logic             ovf_clr
);

  localparam int REC_W = 1 + WIDTH + TS_W;

  logic [TS_W-1:0]  ts_q;
  logic [WIDTH:0]   prev_q;
  logic             first_q;
  logic             ovf_q;
  logic             ovf_d;
  logic [7:0]       drop_cnt_q;
  logic [7:0]       drop_cnt_d;

  logic [WIDTH:0]   cur;
  logic             raise;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [REC_W-1:0] head;

  // Data bits are masked while high-Z so bus noise never looks like a change.
  assign cur   = {oe_n, io & {WIDTH{~oe_n}}};
  assign raise = first_q || (cur != prev_q);
  assign pop   = evt_valid && evt_ready;
  assign drop  = raise && fifo_full && !pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts_q       <= '0;
      prev_q     <= '0;
      first_q    <= 1'b1;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      ts_q       <= ts_q + 1'b1;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
      if (raise) begin
        prev_q  <= cur;
        first_q <= 1'b0;
      end
    end
  end

  // Clear is applied first so a simultaneous drop restarts the count at one.
  always_comb begin
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (drop_cnt_d != GAL_MON_DROP_MAX) begin
        drop_cnt_d = drop_cnt_d + 1'b1;
      end
    end
  end

  gal_mon_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (raise),
    .pop_i   (pop),
    .data_i  ({cur, ts_q}),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_hiz   = head[REC_W-1];
  assign evt_data  = head[REC_W-2:TS_W];
  assign evt_ts    = head[TS_W-1:0];
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

`default_nettype wire

// File: doc/gal_io_monitor.md
# gal_io_monitor

Downstream capture stage for the registered-mode GAL16V8 model. Samples the 8-bit `io` bus and its `oe_n` enable on every clock and detects changes, treating `oe_n = 1` as high-Z. Each change becomes a timestamped event in a small FIFO, drained through a valid/ready stream. Used by benches and board-level checkers to record registered-output behaviour without polling.

## Interface
Parameters:
- `WIDTH`, 8: sampled bus width.
- `DEPTH`, 8: FIFO entries; power of 2, minimum 2.
- `TS_W`, 16: timestamp width.

Ports:
- `clk`  in  1  sole clock; sampling on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `io`  in  WIDTH  GAL output bus as seen at the pins.
- `oe_n`  in  1  GAL output enable, active low; 1 means the bus is high-Z.
- `evt_valid`  out  1  FIFO head holds an event.
- `evt_ready`  in  1  consumer accepts the head.
- `evt_data`  out  WIDTH  sampled bus value; 0 when `evt_hiz` is 1.
- `evt_hiz`  out  1  event records the high-Z state.
- `evt_ts`  out  TS_W  timestamp of the sampling edge.
- `ovf`  out  1  sticky flag: one or more events dropped.
- `drop_cnt`  out  8  dropped-event count, saturates at 255.
- `ovf_clr`  in  1  clears `ovf` and `drop_cnt`.

## Operation
- Timestamp counter `ts_q` increments by 1 every cycle. It wraps from 2^TS_W−1 to 0 with no flag.
- Normalised sample: `cur = {oe_n, oe_n ? 0 : io}`. Data is ignored while high-Z, so bus noise under `oe_n = 1` generates no events.
- Register `prev_q` holds the last normalised sample. Flag `first_q` is set by reset.
- An event is raised at an edge when `first_q == 1` or `cur != prev_q`. At that edge:
  - `prev_q <= cur`
  - `first_q <= 0`
  - the record `{hiz, data, ts_q}` is pushed.
- Pop occurs when `evt_valid && evt_ready`.
- Push while full:
  - If a pop happens in the same cycle, the push is accepted and the count is unchanged.
  - Otherwise the event is dropped, `ovf <= 1`, and `drop_cnt` increments (saturating).
  - `prev_q` updates even when the event is dropped.
- Push while empty together with `evt_ready = 1`: the new event appears on the next cycle. There is no same-cycle bypass.
- `ovf_clr` in the same cycle as a drop: the drop wins, giving `ovf = 1` and `drop_cnt = 1`.
- Output ordering is strictly FIFO. Head fields stay stable while `evt_valid && !evt_ready`.

## Timing
- Reset values:
  - `evt_valid = 0`, `evt_data = 0`, `evt_hiz = 0`, `evt_ts = 0`
  - `ovf = 0`, `drop_cnt = 0`
  - `ts_q = 0`, `first_q = 1`, FIFO empty
- Reset asserted mid-operation flushes the FIFO immediately (asynchronously). Pending events are lost and are not counted as drops.
- The first edge after reset release always pushes a baseline event with `ts = 0`.
- Latency: a change present before edge k makes `evt_valid` go high after edge k. Its `evt_ts` equals the `ts_q` value just before edge k.
- Read path is first-word-fall-through: head fields are driven combinationally from the storage array indexed by the read pointer.
- Throughput: one push and one pop per cycle.
- Full-FIFO latency bound: an event reaches the head after at most DEPTH pops.

## Structure
- Package `gal_mon_pkg` holds:
  - `gal_evt_t` struct `{hiz, data[7:0], ts[15:0]}`, built on the default widths.
  - Constants `GAL_MON_TS_W` and `GAL_MON_DROP_MAX`.
- Sub-module `gal_mon_fifo` (parameters DEPTH and W) provides:
  - generic synchronous FIFO with async reset
  - full/empty flags derived from pointers one bit wider than the address
  - `push`/`pop` inputs and first-word-fall-through output
- The top level contains the timestamp counter, the change detector and the overflow logic.

## Test plan
- Reset: release `rst` with `oe_n = 0`, `io = 0x00` → one event `{hiz 0, data 0x00, ts 0}`; all other outputs at their reset values.
- Sequence: `io` = 0x00, 0x01, 0x02, 0x03, 0x0D, each held 1 cycle, `evt_ready = 1` → 5 events in order, timestamps consecutive.
- High-Z: hold `io = 0x0D`, then `oe_n = 1` while toggling `io` → exactly one event `{hiz 1, data 0x00}`. Restoring `oe_n = 0` gives one event with `data 0x0D`.
- Overflow: `evt_ready = 0` with 10 distinct `io` changes → 8 events stored, `ovf = 1`, `drop_cnt = 2`. Draining yields the first 8 in order. Asserting `ovf_clr` then gives `ovf = 0`, `drop_cnt = 0`.
- Full with simultaneous push and pop: FIFO at 8 entries, one change plus `evt_ready = 1` → no drop, occupancy stays 8.
- Reset mid-stream: 4 events queued, pulse `rst` → `evt_valid = 0` immediately, then a baseline event with `ts 0` after release.
